// File: rtl/bypass_rf_wport_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter and the
// register-file wrapper that consumes its write ports.
package bypass_rf_wport_arb_pkg;

  localparam int unsigned DEF_NAME_W = 3;
  localparam int unsigned DEF_DATA_W = 32;

  // One write as seen on a register-file data-write port at default widths.
  typedef struct packed {
    logic [DEF_NAME_W-1:0] name;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

`ifndef BRF_WPORT_MACROS
`define BRF_WPORT_MACROS
// Field idx of width w inside a flat packed vector (requester 0 in the LSBs).
`define BRF_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/bypass_rf_wport_arb_rr_pick2.sv
// Circular find-first-two picker: g1 is the first valid entry at or after
// the pointer, g2 the next valid entry after g1 whose name differs from g1's.
module rr_pick2 #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NAME_W  = 3
) (
  input  logic [NUM_REQ-1:0]          valid_i,
  input  logic [NUM_REQ*NAME_W-1:0]   names_i,
  input  logic [$clog2(NUM_REQ)-1:0]  ptr_i,
  output logic                        g1_vld_o,
  output logic [$clog2(NUM_REQ)-1:0]  g1_idx_o,
  output logic                        g2_vld_o,
  output logic [$clog2(NUM_REQ)-1:0]  g2_idx_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W:0]    sum;
  logic [PTR_W-1:0]  pos;
  logic [NAME_W-1:0] g1_name;

  // Scan once around the ring starting at ptr_i; the scan stops before
  // wrapping back onto ptr_i, so g2 never precedes g1 in round-robin order.
  always_comb begin
    g1_vld_o = 1'b0;
    g1_idx_o = '0;
    g2_vld_o = 1'b0;
    g2_idx_o = '0;
    g1_name  = '0;
    sum      = '0;
    pos      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      pos = sum[PTR_W-1:0];
      if (!g1_vld_o && valid_i[pos]) begin
        g1_vld_o = 1'b1;
        g1_idx_o = pos;
        g1_name  = `BRF_FIELD(names_i, pos, NAME_W);
      end else if (g1_vld_o && !g2_vld_o && valid_i[pos] &&
                   (`BRF_FIELD(names_i, pos, NAME_W) != g1_name)) begin
        g2_vld_o = 1'b1;
        g2_idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/bypass_rf_wport_arb.sv
// Shares the two data-write ports of the bypassing register file among
// NUM_REQ writeback stages via one-entry holding buffers and a round-robin
// scheduler that issues up to two writes per cycle.
module bypass_rf_wport_arb
  import bypass_rf_wport_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned name_width = DEF_NAME_W,
  parameter int unsigned data_width = DEF_DATA_W,
  parameter int unsigned cnt_width  = $clog2(NUM_REQ + 1)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               REQ_VALID,
  output logic [NUM_REQ-1:0]               REQ_READY,
  input  logic [NUM_REQ*name_width-1:0]    REQ_NAME,
  input  logic [NUM_REQ*data_width-1:0]    REQ_DATA,
  input  logic                             FLUSH,
  output logic                             WE_1,
  output logic [name_width-1:0]            NAME_IN_1,
  output logic [data_width-1:0]            D_IN_1,
  output logic                             WE_2,
  output logic [name_width-1:0]            NAME_IN_2,
  output logic [data_width-1:0]            D_IN_2,
  output logic [cnt_width-1:0]             PENDING
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [name_width-1:0] name;
    logic [data_width-1:0] data;
  } req_t;

  logic [NUM_REQ-1:0]            buf_valid_q, buf_valid_d;
  req_t                          buf_q [NUM_REQ];
  req_t                          buf_d [NUM_REQ];
  logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ*name_width-1:0] buf_names;
  logic                          g1_vld, g2_vld;
  logic [PTR_W-1:0]              g1_idx, g2_idx;
  logic [NUM_REQ-1:0]            granted;
  logic [NUM_REQ-1:0]            accept;

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Flatten buffered names for the picker.
  always_comb begin
    buf_names = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      `BRF_FIELD(buf_names, i, name_width) = buf_q[i].name;
    end
  end

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .NAME_W  (name_width)
  ) u_pick (
    .valid_i  (buf_valid_q),
    .names_i  (buf_names),
    .ptr_i    (rr_ptr_q),
    .g1_vld_o (g1_vld),
    .g1_idx_o (g1_idx),
    .g2_vld_o (g2_vld),
    .g2_idx_o (g2_idx)
  );

  // Drive write ports from the granted buffers; idle ports present zeros.
  always_comb begin
    granted   = '0;
    WE_1      = 1'b0;
    NAME_IN_1 = '0;
    D_IN_1    = '0;
    WE_2      = 1'b0;
    NAME_IN_2 = '0;
    D_IN_2    = '0;
    if (g1_vld && !FLUSH) begin
      granted[g1_idx] = 1'b1;
      WE_1            = 1'b1;
      NAME_IN_1       = buf_q[g1_idx].name;
      D_IN_1          = buf_q[g1_idx].data;
    end
    if (g2_vld && !FLUSH) begin
      granted[g2_idx] = 1'b1;
      WE_2            = 1'b1;
      NAME_IN_2       = buf_q[g2_idx].name;
      D_IN_2          = buf_q[g2_idx].data;
    end
  end

  // Handshake: a buffer that drains this cycle may be refilled in the same cycle.
  always_comb begin
    REQ_READY = {NUM_REQ{RST && !FLUSH}} & (~buf_valid_q | granted);
    accept    = REQ_VALID & REQ_READY;
  end

  // Next buffer state and round-robin pointer (advances past the last grant).
  always_comb begin
    buf_valid_d = buf_valid_q;
    rr_ptr_d    = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      buf_d[i] = buf_q[i];
      if (FLUSH) begin
        buf_valid_d[i] = 1'b0;
      end else if (accept[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_d[i].name  = `BRF_FIELD(REQ_NAME, i, name_width);
        buf_d[i].data  = `BRF_FIELD(REQ_DATA, i, data_width);
      end else if (granted[i]) begin
        buf_valid_d[i] = 1'b0;
      end
    end
    if (!FLUSH) begin
      if (g2_vld) begin
        rr_ptr_d = ptr_after(g2_idx);
      end else if (g1_vld) begin
        rr_ptr_d = ptr_after(g1_idx);
      end
    end
  end

  // Occupancy count from registered buffer state only.
  always_comb begin
    PENDING = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      PENDING = PENDING + cnt_width'(buf_valid_q[i]);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // A newly accepted write must not reuse a name still held by another
  // requester's buffer, unless it is an identical (name, data) write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          if (i != j && accept[i] && buf_valid_q[j] && !granted[j] &&
              (`BRF_FIELD(REQ_NAME, i, name_width) == buf_q[j].name)) begin
            assert (`BRF_FIELD(REQ_DATA, i, data_width) == buf_q[j].data);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bypass_rf_wport_arb.sv
// Directed bench for the register-file write-port arbiter.
module tb_bypass_rf_wport_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned NW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            FLUSH = 1'b0;
  logic [N-1:0]    REQ_VALID;
  logic [N-1:0]    REQ_READY;
  logic [N*NW-1:0] REQ_NAME;
  logic [N*DW-1:0] REQ_DATA;
  logic            WE_1, WE_2;
  logic [NW-1:0]   NAME_IN_1, NAME_IN_2;
  logic [DW-1:0]   D_IN_1, D_IN_2;
  logic [CW-1:0]   PENDING;

  int passed = 0;
  int total  = 0;

  bypass_rf_wport_arb #(
    .NUM_REQ    (N),
    .name_width (NW),
    .data_width (DW),
    .cnt_width  (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_NAME  (REQ_NAME),
    .REQ_DATA  (REQ_DATA),
    .FLUSH     (FLUSH),
    .WE_1      (WE_1),
    .NAME_IN_1 (NAME_IN_1),
    .D_IN_1    (D_IN_1),
    .WE_2      (WE_2),
    .NAME_IN_2 (NAME_IN_2),
    .D_IN_2    (D_IN_2),
    .PENDING   (PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input int unsigned i, input logic [NW-1:0] n, input logic [DW-1:0] d);
    REQ_VALID[i]         = 1'b1;
    REQ_NAME[i*NW +: NW] = n;
    REQ_DATA[i*DW +: DW] = d;
  endtask

  initial begin
    REQ_VALID = 4'b1111;
    REQ_NAME  = '0;
    REQ_DATA  = '0;

    // Reset held three cycles with all requesters offering.
    step(); step(); step();
    chk("rst_we1", WE_1, 0);
    chk("rst_we2", WE_2, 0);
    chk("rst_ready", REQ_READY, 4'b0000);
    chk("rst_pending", PENDING, 0);
    RST = 1'b1;
    #1;
    chk("rel_ready", REQ_READY, 4'b1111);
    REQ_VALID = '0;

    // Single writer: one-cycle latency to WE_1.
    offer(0, 3'd5, 32'hDEADBEEF);
    step();
    REQ_VALID = '0;
    #1;
    chk("single_we1", WE_1, 1);
    chk("single_name1", NAME_IN_1, 5);
    chk("single_d1", D_IN_1, 32'hDEADBEEF);
    chk("single_we2", WE_2, 0);
    chk("single_pend1", PENDING, 1);
    step();
    chk("single_pend0", PENDING, 0);
    chk("single_idle_we1", WE_1, 0);
    chk("single_idle_name1", NAME_IN_1, 0);
    chk("single_idle_d1", D_IN_1, 0);

    // Reset pulse to bring the pointer back to 0.
    RST = 1'b0;
    #1;
    step();
    RST = 1'b1;
    #1;

    // All four streaming with distinct names: (0,1),(2,3),(0,1),(2,3).
    offer(0, 3'd1, 32'h100);
    offer(1, 3'd2, 32'h101);
    offer(2, 3'd4, 32'h102);
    offer(3, 3'd7, 32'h103);
    step();
    #1;
    chk("rr_a_name1", NAME_IN_1, 1);
    chk("rr_a_name2", NAME_IN_2, 2);
    chk("rr_a_d1", D_IN_1, 32'h100);
    chk("rr_a_d2", D_IN_2, 32'h101);
    chk("rr_a_ready", REQ_READY, 4'b0011);
    chk("rr_a_pend", PENDING, 4);
    step();
    chk("rr_b_name1", NAME_IN_1, 4);
    chk("rr_b_name2", NAME_IN_2, 7);
    chk("rr_b_ready", REQ_READY, 4'b1100);
    chk("rr_b_pend", PENDING, 4);
    step();
    chk("rr_c_name1", NAME_IN_1, 1);
    chk("rr_c_name2", NAME_IN_2, 2);
    chk("rr_c_pend", PENDING, 4);
    REQ_VALID = '0;
    step();
    chk("rr_d_name1", NAME_IN_1, 4);
    chk("rr_d_name2", NAME_IN_2, 7);
    chk("rr_d_pend", PENDING, 2);
    step();
    chk("rr_e_pend", PENDING, 0);

    // Flush with three buffers full; pointer (0) must survive.
    offer(0, 3'd1, 32'h200);
    offer(1, 3'd2, 32'h201);
    offer(2, 3'd4, 32'h202);
    step();
    REQ_VALID = '0;
    FLUSH = 1'b1;
    #1;
    chk("fl_we1", WE_1, 0);
    chk("fl_we2", WE_2, 0);
    chk("fl_ready", REQ_READY, 4'b0000);
    chk("fl_pend3", PENDING, 3);
    step();
    FLUSH = 1'b0;
    #1;
    chk("fl_pend0", PENDING, 0);
    chk("fl_after_we1", WE_1, 0);
    offer(0, 3'd1, 32'h300);
    offer(1, 3'd2, 32'h301);
    offer(2, 3'd4, 32'h302);
    offer(3, 3'd7, 32'h303);
    step();
    REQ_VALID = '0;
    #1;
    chk("fl_ptr_name1", NAME_IN_1, 1);
    chk("fl_ptr_name2", NAME_IN_2, 2);
    step();
    step();
    chk("fl_drain_pend", PENDING, 0);

    // Name clash: buffers 0 and 1 both name 3, buffer 2 name 6.
    offer(0, 3'd3, 32'hA1);
    offer(1, 3'd3, 32'hB2);
    offer(2, 3'd6, 32'hC3);
    step();
    REQ_VALID = '0;
    #1;
    chk("nc1_we1", WE_1, 1);
    chk("nc1_name1", NAME_IN_1, 3);
    chk("nc1_d1", D_IN_1, 32'hA1);
    chk("nc1_we2", WE_2, 1);
    chk("nc1_name2", NAME_IN_2, 6);
    chk("nc1_d2", D_IN_2, 32'hC3);
    chk("nc1_pend", PENDING, 3);
    step();
    chk("nc2_we1", WE_1, 1);
    chk("nc2_name1", NAME_IN_1, 3);
    chk("nc2_d1", D_IN_1, 32'hB2);
    chk("nc2_we2", WE_2, 0);
    chk("nc2_pend", PENDING, 1);
    step();
    chk("nc3_pend", PENDING, 0);
    chk("nc3_we1", WE_1, 0);

    // Asynchronous reset between edges with three writes pending.
    offer(0, 3'd1, 32'h400);
    offer(1, 3'd2, 32'h401);
    offer(3, 3'd7, 32'h403);
    step();
    REQ_VALID = '0;
    #1;
    chk("ar_pend3", PENDING, 3);
    chk("ar_we1_pre", WE_1, 1);
    #1;
    RST = 1'b0;
    #1;
    chk("ar_we1", WE_1, 0);
    chk("ar_we2", WE_2, 0);
    chk("ar_pend0", PENDING, 0);
    chk("ar_ready", REQ_READY, 4'b0000);
    #1;
    RST = 1'b1;
    step();
    chk("ar_post_we1", WE_1, 0);
    chk("ar_post_we2", WE_2, 0);
    chk("ar_post_pend", PENDING, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
